// File: rtl/kianv_mem_arbiter.sv
// Round-robin arbiter: NUM_PORTS valid/ready masters onto one memory bus.
// Optional watchdog: define KIANV_ARB_TIMEOUT_EN.
module kianv_mem_arbiter #(
    parameter int          NUM_PORTS      = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF,
    localparam int         GW             = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_PORTS-1:0]    s_mem_valid,
    output logic [NUM_PORTS-1:0]    s_mem_ready,
    input  logic [4*NUM_PORTS-1:0]  s_mem_wstrb,
    input  logic [32*NUM_PORTS-1:0] s_mem_addr,
    input  logic [32*NUM_PORTS-1:0] s_mem_wdata,
    output logic [31:0]             s_mem_rdata,
    output logic                    m_mem_valid,
    input  logic                    m_mem_ready,
    output logic [3:0]              m_mem_wstrb,
    output logic [31:0]             m_mem_addr,
    output logic [31:0]             m_mem_wdata,
    input  logic [31:0]             m_mem_rdata,
    output logic [GW-1:0]           grant_id,
    output logic                    timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] winner;
    logic          any_req;
    logic          tmo;
    logic          done;

    assign grant_id = grant_q;

    // Round-robin pick: highest priority is the port just after the last grant
    always_comb begin
        int idx;
        winner  = grant_q;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(grant_q) + k) % NUM_PORTS;
            if (s_mem_valid[idx]) begin
                winner  = GW'(idx);
                any_req = 1'b1;
            end
        end
    end

`ifdef KIANV_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_err_q;

    assign tmo = (state == BUSY) && !m_mem_ready
              && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_err_q;

    // Watchdog counts BUSY cycles without ready; zero whenever idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!m_mem_ready) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_err_q <= 1'b0;
        end else if (tmo) begin
            tmo_err_q <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done = (state == BUSY) && (m_mem_ready || tmo);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant register; reset to last port so the first search starts at 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= GW'(NUM_PORTS - 1);
        end else if (state == IDLE && any_req) begin
            grant_q <= winner;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = BUSY;
            BUSY: if (done)    state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // Outputs: bus mux from the granted port, one-hot completion
    always_comb begin
        s_mem_ready = '0;
        m_mem_valid = (state == BUSY);
        m_mem_wstrb = '0;
        m_mem_addr  = s_mem_addr[32*int'(grant_q) +: 32];
        m_mem_wdata = s_mem_wdata[32*int'(grant_q) +: 32];
        s_mem_rdata = tmo ? ERR_RDATA : m_mem_rdata;
        if (state == BUSY) begin
            m_mem_wstrb = s_mem_wstrb[4*int'(grant_q) +: 4];
        end
        if (done) begin
            s_mem_ready[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_kianv_mem_arbiter.sv
// Randomized bench for kianv_mem_arbiter against a transaction-level model.
// Define KIANV_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_kianv_mem_arbiter;

    localparam int N  = 4;
    localparam int TC = 8;
    localparam int GW = $clog2(N);

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      s_mem_valid;
    logic [N-1:0]      s_mem_ready;
    logic [4*N-1:0]    s_mem_wstrb;
    logic [32*N-1:0]   s_mem_addr;
    logic [32*N-1:0]   s_mem_wdata;
    logic [31:0]       s_mem_rdata;
    logic              m_mem_valid;
    logic              m_mem_ready;
    logic [3:0]        m_mem_wstrb;
    logic [31:0]       m_mem_addr;
    logic [31:0]       m_mem_wdata;
    logic [31:0]       m_mem_rdata;
    logic [GW-1:0]     grant_id;
    logic              timeout_err;

    kianv_mem_arbiter #(
        .NUM_PORTS      (N),
        .TIMEOUT_CYCLES (TC),
        .ERR_RDATA      (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .s_mem_valid (s_mem_valid),
        .s_mem_ready (s_mem_ready),
        .s_mem_wstrb (s_mem_wstrb),
        .s_mem_addr  (s_mem_addr),
        .s_mem_wdata (s_mem_wdata),
        .s_mem_rdata (s_mem_rdata),
        .m_mem_valid (m_mem_valid),
        .m_mem_ready (m_mem_ready),
        .m_mem_wstrb (m_mem_wstrb),
        .m_mem_addr  (m_mem_addr),
        .m_mem_wdata (m_mem_wdata),
        .m_mem_rdata (m_mem_rdata),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // master-side pending requests
    bit          req   [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [3:0]  wstrb [N];

    // reference model: who owns the bus, who was served last
    int owner;
    int last;
    int busy_cycles;
    bit err_model;
    int grant_log[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner       = -1;
        last        = N - 1;
        busy_cycles = 0;
        err_model   = 1'b0;
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        wstrb[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endtask

    task automatic drive_bus();
        for (int p = 0; p < N; p++) begin
            s_mem_valid[p]        = req[p];
            s_mem_addr[32*p +: 32]  = addr[p];
            s_mem_wdata[32*p +: 32] = wdata[p];
            s_mem_wstrb[4*p +: 4]   = wstrb[p];
        end
    endtask

    // one clock: drive, compare against model, advance model to next cycle
    task automatic step();
        bit busy;
        bit to;
        bit done;
        logic [N-1:0] exp_rdy;
        drive_bus();
        #1;
        busy = (owner >= 0);
        to   = 1'b0;
`ifdef KIANV_ARB_TIMEOUT_EN
        to = busy && !m_mem_ready && (busy_cycles == TC - 1);
`endif
        done    = busy && (m_mem_ready || to);
        exp_rdy = '0;
        if (done) exp_rdy[owner] = 1'b1;
        chk("m_valid", 32'(m_mem_valid), 32'(busy));
        chk("grant", 32'(grant_id), 32'(last));
        chk("s_ready", 32'(s_mem_ready), 32'(exp_rdy));
        chk("tmo_err", 32'(timeout_err), 32'(err_model));
        if (busy) begin
            chk("m_addr", m_mem_addr, addr[owner]);
            chk("m_wdata", m_mem_wdata, wdata[owner]);
            chk("m_wstrb", 32'(m_mem_wstrb), 32'(wstrb[owner]));
        end else begin
            chk("idle_wstrb", 32'(m_mem_wstrb), 32'h0);
        end
        if (done) begin
            chk("rdata", s_mem_rdata, to ? 32'hDEADBEEF : m_mem_rdata);
        end
        if (busy) begin
            if (done) begin
                req[owner] = 1'b0;
                if (to) err_model = 1'b1;
                owner = -1;
            end else begin
                busy_cycles++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req[(last + k) % N]) begin
                    owner = (last + k) % N;
                end
            end
            if (owner >= 0) begin
                last        = owner;
                busy_cycles = 0;
                grant_log.push_back(owner);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_mem_valid), 32'h0);
        chk("rst_m_wstrb", 32'(m_mem_wstrb), 32'h0);
        chk("rst_s_ready", 32'(s_mem_ready), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'(N - 1));
        chk("rst_tmo_err", 32'(timeout_err), 32'h0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        m_mem_ready = 1'b0;
        m_mem_rdata = '0;
        for (int p = 0; p < N; p++) begin
            req[p] = 1'b0; addr[p] = '0; wdata[p] = '0; wstrb[p] = '0;
        end
        drive_bus();
        @(negedge clk);
        do_reset();

        // port0 read of 0x100, memory answers in its first cycle
        req[0] = 1'b1; addr[0] = 32'h100; wdata[0] = '0; wstrb[0] = 4'h0;
        step();
        m_mem_ready = 1'b1;
        m_mem_rdata = 32'h12345678;
        drive_bus();
        #1;
        chk("d034_ready", 32'(s_mem_ready), 32'h1);
        chk("d034_rdata", s_mem_rdata, 32'h12345678);
        chk("d034_grant", 32'(grant_id), 32'h0);
        #1;
        step();
        m_mem_ready = 1'b0;
        step();

        // port1 write while others idle
        req[1] = 1'b1; addr[1] = 32'h200;
        wdata[1] = 32'hAABBCCDD; wstrb[1] = 4'h3;
        step();
        m_mem_ready = 1'b1;
        drive_bus();
        #1;
        chk("d036_wdata", m_mem_wdata, 32'hAABBCCDD);
        chk("d036_wstrb", 32'(m_mem_wstrb), 32'h3);
        chk("d036_ready", 32'(s_mem_ready), 32'h2);
        #1;
        step();
        m_mem_ready = 1'b0;
        step();

        // all ports requesting continuously: strict rotation
        grant_log.delete();
        m_mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < N; p++) if (!req[p]) new_req(p);
            step();
        end
        for (int p = 0; p < N; p++) req[p] = 1'b0;
        m_mem_ready = 1'b0;
        step();
        chk("d035_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("d035_order", 32'(grant_log[i]), 32'((2 + i) % N));
        end

`ifdef KIANV_ARB_TIMEOUT_EN
        // ready exactly in the timeout cycle wins
        new_req(2);
        step();
        repeat (TC - 1) step();
        m_mem_ready = 1'b1;
        m_mem_rdata = 32'h0BADF00D;
        step();
        m_mem_ready = 1'b0;
        chk("d039_no_err", 32'(timeout_err), 32'h0);
        // no ready at all: watchdog completes with error data
        new_req(3);
        new_req(0);
        repeat (TC + 2) step();
        chk("d038_err", 32'(timeout_err), 32'h1);
        m_mem_ready = 1'b1;
        repeat (3) step();
        m_mem_ready = 1'b0;
`endif

        // reset three cycles into BUSY aborts the access
        for (int p = 0; p < N; p++) req[p] = 1'b0;
        step();
        do_reset();
        new_req(2);
        step();
        new_req(0);
        repeat (3) step();
        resetn = 1'b0;
        #1;
        chk("d037_m_valid", 32'(m_mem_valid), 32'h0);
        chk("d037_s_ready", 32'(s_mem_ready), 32'h0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        grant_log.delete();
        step();
        chk("d037_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'h0);
        m_mem_ready = 1'b1;
        repeat (4) step();
        m_mem_ready = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!req[p] && $urandom_range(0, 99) < 40) new_req(p);
            end
            m_mem_ready = ($urandom_range(0, 99) < 40);
            m_mem_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kianv_mem_arbiter.md
KIANV_MEM_ARBITER -- requirements
Module: kianv_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, giving the number of requesting cores/masters (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit in clk cycles (legal 2..65535).
REQ-003 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, giving the read data returned on a timed-out access.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port resetn, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port s_mem_valid, input, NUM_PORTS, the per-port request.
REQ-007 SHALL have port s_mem_ready, output, NUM_PORTS, the per-port completion.
REQ-008 SHALL have port s_mem_wstrb, input, 4*NUM_PORTS, the per-port byte strobes; port i is at [4i+3:4i].
REQ-009 SHALL have port s_mem_addr, input, 32*NUM_PORTS, the per-port address; port i is at [32i+31:32i].
REQ-010 SHALL have port s_mem_wdata, input, 32*NUM_PORTS, the per-port write data.
REQ-011 SHALL have port s_mem_rdata, output, 32, the read data shared by all ports.
REQ-012 SHALL have ports m_mem_valid (output, 1), m_mem_ready (input, 1), m_mem_wstrb (output, 4), m_mem_addr (output, 32), m_mem_wdata (output, 32) and m_mem_rdata (input, 32), forming the downstream memory bus.
REQ-013 SHALL have port grant_id, output, clog2(NUM_PORTS), the currently or last granted port.
REQ-014 SHALL have port timeout_err, output, 1, a sticky watchdog flag.

Function
REQ-015 SHALL use the valid/ready protocol: a master holds valid, wstrb, addr and wdata stable until ready; wstrb==0 means read.
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 IDLE: if any s_mem_valid is high, SHALL register the winner into grant_id and enter BUSY next cycle; otherwise it SHALL stay in IDLE.
REQ-018 SHALL use round-robin arbitration, searching from (last grant+1) mod NUM_PORTS upward with wrap; after reset the search starts at port 0.
REQ-019 BUSY: m_mem_valid SHALL be 1, and m_mem_wstrb, m_mem_addr and m_mem_wdata SHALL be combinationally muxed from port grant_id.
REQ-020 BUSY with m_mem_ready=1: s_mem_ready[grant_id] SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-021 s_mem_rdata SHALL equal m_mem_rdata combinationally; it is valid only while a s_mem_ready bit is set.
REQ-022 Minimum latency from request to ready SHALL be 2 cycles: 1 arbitration cycle plus at least 1 memory cycle; there is one IDLE bubble between grants.
REQ-023 Non-granted ports SHALL see s_mem_ready=0; at most one s_mem_ready bit SHALL be set in any cycle.
REQ-024 In IDLE, m_mem_valid SHALL be 0 and m_mem_wstrb SHALL be 0.
REQ-025 A request arriving in the same cycle as another port's completion SHALL be eligible at the next IDLE cycle.
REQ-026 A granted port that drops valid is a protocol violation; the arbiter SHALL still complete the access and discard the result.

Reset
REQ-027 Asserting resetn low SHALL immediately force IDLE, s_mem_ready=0, m_mem_valid=0, m_mem_wstrb=0, grant_id=NUM_PORTS-1 (so the first search starts at port 0), timeout counter=0 and timeout_err=0.
REQ-028 Reset mid-BUSY SHALL abort the access with no s_mem_ready pulse; masters restart after reset.
REQ-029 resetn is deasserted synchronously to clk externally; the block adds no reset synchroniser.

Configuration
REQ-030 Macro KIANV_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without m_mem_ready.
REQ-031 With KIANV_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without ready: s_mem_ready[grant_id]=1, s_mem_rdata=ERR_RDATA, m_mem_valid=0 from the next cycle, timeout_err set until reset, and return to IDLE.
REQ-032 With KIANV_ARB_TIMEOUT_EN defined, m_mem_ready arriving in the timeout cycle SHALL win, giving a normal completion with no error.
REQ-033 Macro KIANV_ARB_TIMEOUT_EN undefined: there SHALL be no counter, BUSY SHALL wait indefinitely, and timeout_err SHALL be tied 0.

Verification
REQ-034 NUM_PORTS=2: port0 reads 0x100 and memory returns 0x12345678 after 1 cycle -> s_mem_ready[0] asserts 2 cycles after valid, s_mem_rdata=0x12345678, grant_id=0.
REQ-035 NUM_PORTS=4: all ports request continuously -> grants occur in order 0,1,2,3,0, with exactly one IDLE bubble between grants.
REQ-036 Port1 writes wstrb=0x3 and wdata=0xAABBCCDD while port0 is idle -> m_mem_* carries port1's values and only s_mem_ready[1] pulses.
REQ-037 Reset asserted 3 cycles into BUSY -> m_mem_valid=0 immediately, no ready pulse, and the first grant after reset goes to port 0.
REQ-038 KIANV_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and m_mem_ready held 0 -> ready pulse 8 cycles after entering BUSY, rdata=0xDEADBEEF, timeout_err=1; the next port is then served normally.
REQ-039 KIANV_ARB_TIMEOUT_EN with m_mem_ready asserted in cycle TIMEOUT_CYCLES-1 -> normal data returned and timeout_err stays 0.
